// File: rtl/fpu_pkg.sv
// ============================================================================
// fpu_pkg : shared types and constants for the FPU sharing arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1
  } fpu_op_e;

  localparam logic [31:0] c_nan_val = 32'h7FC0_0000;

endpackage

`default_nettype wire

// File: rtl/fpu_arbiter_rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-way round-robin winner select, purely combinational
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       rr_last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // on a tie the requester that was not served last wins
      2'b11:   grant_o = rr_last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fpu_arbiter.sv
// ============================================================================
// fpu_arbiter : shares one multi-cycle FPU between two requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               TIMEOUT_CYCLES = 64,
  parameter logic [WIDTH-1:0] NAN_VAL        = WIDTH'(c_nan_val)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_r,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_r,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic [1:0]       fpu_op,
  output logic             fpu_start,
  output logic             fpu_clr,
  input  logic             fpu_done,
  input  logic [WIDTH-1:0] fpu_r,
  output logic             busy,
  output logic [7:0]       timeout_cnt
);

  localparam logic [7:0] c_wait_last = 8'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   rr_last_q, rr_last_d;
  logic [7:0]             wcnt_q, wcnt_d;
  logic [7:0]             tcnt_q, tcnt_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [1:0]             op_q, op_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [1:0]             rsp_err_q, rsp_err_d;
  logic [1:0][WIDTH-1:0]  rsp_r_q, rsp_r_d;

  logic [1:0] w_req_valid;
  logic [1:0] w_grant;
  logic [1:0] w_rsp_ready;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  rr_arbiter2 u_rr (
    .valid_i   (w_req_valid),
    .rr_last_i (rr_last_q),
    .grant_o   (w_grant)
  );

  assign {req1_ready, req0_ready} = (state_q == ST_IDLE) ? w_grant : 2'b00;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_r_d     = rsp_r_q;
    fpu_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|w_grant) begin
          owner_d = w_grant[1];
          a_d     = w_grant[1] ? req1_a  : req0_a;
          b_d     = w_grant[1] ? req1_b  : req0_b;
          op_d    = w_grant[1] ? req1_op : req0_op;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // a completion on the final watchdog cycle still counts as success
        if (fpu_done) begin
          rsp_r_d[owner_q]     = fpu_r;
          rsp_err_d[owner_q]   = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = ST_RESP;
        end else if (wcnt_q == c_wait_last) begin
          fpu_clr              = 1'b1;
          rsp_r_d[owner_q]     = NAN_VAL;
          rsp_err_d[owner_q]   = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          if (tcnt_q != 8'hFF) begin
            tcnt_d = tcnt_q + 8'd1;
          end
          state_d              = ST_RESP;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        // result is cleared too so an idle port always reads as all-zero
        if (w_rsp_ready[owner_q]) begin
          rsp_r_d[owner_q]     = '0;
          rsp_err_d[owner_q]   = 1'b0;
          rsp_valid_d[owner_q] = 1'b0;
          rr_last_d            = owner_q;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      wcnt_q      <= 8'd0;
      tcnt_q      <= 8'd0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      rsp_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_r_q     <= rsp_r_d;
    end
  end

  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign fpu_op      = op_q;
  assign fpu_start   = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign timeout_cnt = tcnt_q;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp0_err    = rsp_err_q[0];
  assign rsp0_r      = rsp_r_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp1_err    = rsp_err_q[1];
  assign rsp1_r      = rsp_r_q[1];

endmodule

`default_nettype wire
